// File: rtl/div_pkg.sv
// div_pkg: state encoding and sizing constants shared by the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W = $clog2(DEFAULT_WIDTH);
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake with operand and result buses
interface seq_divider_if import div_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic busy;
  logic done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_divider_ripple_borrow_sub.sv
// ripple_borrow_sub: a - b through a chain of full-subtractor cells
module ripple_borrow_sub #(parameter int N = 5) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);
  logic [N:0] bw;
  assign bw[0] = 1'b0;
  for (genvar i = 0; i < N; i++) begin : g_fs
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & (b[i] | bw[i])) | (b[i] & bw[i]);
  end
  assign borrow_out = bw[N];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one trial subtraction per clock; DIV_ZERO_CHECK_EN short-cuts zero divisors
module seq_divider import div_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic clk,
  input logic rst,
  seq_divider_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] r_q, r_d, r_sh, diff;
  logic [WIDTH-1:0] q_q, q_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
  logic dbz_q, dbz_d, borrow, accept;
  assign accept = (state_q == IDLE) && bus.start;
  assign r_sh = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
  ripple_borrow_sub #(.N(WIDTH+1)) u_sub (.a(r_sh), .b({1'b0, dvs_q}), .diff(diff), .borrow_out(borrow));
  // next state: operand capture, one restoring iteration per RUN cycle, result load on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    if (accept) begin
      state_d = RUN;
      cnt_d = CW'(WIDTH-1);
      r_d = '0;
      q_d = bus.dividend;
      dvs_d = bus.divisor;
`ifdef DIV_ZERO_CHECK_EN
      if (bus.divisor == '0) begin
        state_d = DONE;
        quo_d = '1;
        rem_d = bus.dividend;
        dbz_d = 1'b1;
      end
`endif
    end else if (state_q == RUN) begin
      r_d = borrow ? r_sh : diff;
      q_d = {q_q[WIDTH-2:0], ~borrow};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = DONE;
        cnt_d = '0;
        quo_d = q_d;
        rem_d = r_d[WIDTH-1:0];
        dbz_d = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.quotient = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table, hand-written corner sequences and sweeps against an arithmetic model
module tb_seq_divider;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  seq_divider_if #(.WIDTH(4)) b4 ();
  seq_divider_if #(.WIDTH(8)) b8 ();
  seq_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif
  typedef struct { int a; int b; int q; int r; } vec_t;
  vec_t tbl [7];
  int checks = 0;
  int errors = 0;
  function automatic int exp_q(input int a, input int b, input int w);
    return (b == 0) ? (1 << w) - 1 : a / b;
  endfunction
  function automatic int exp_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction
  function automatic int exp_lat(input int b, input int w);
    return (ZC && b == 0) ? 1 : w + 1;
  endfunction
  function automatic int exp_z(input int b);
    return (ZC && b == 0) ? 1 : 0;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input int w, input int a, input int b, output int q, output int r,
                     output int z, output int lat, output int dlen);
    if (w == 4) begin
      b4.dividend = 4'(a); b4.divisor = 4'(b); b4.start = 1;
    end else begin
      b8.dividend = 8'(a); b8.divisor = 8'(b); b8.start = 1;
    end
    @(posedge clk); #1;
    b4.start = 0; b8.start = 0;
    lat = 1;
    while (!(w == 4 ? b4.done : b8.done) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = (w == 4) ? int'(b4.quotient) : int'(b8.quotient);
    r = (w == 4) ? int'(b4.remainder) : int'(b8.remainder);
    z = (w == 4) ? int'(b4.div_by_zero) : int'(b8.div_by_zero);
    @(posedge clk); #1;
    dlen = 1 + ((w == 4 ? b4.done : b8.done) ? 1 : 0);
  endtask
  task automatic do_case(input int w, input int a, input int b);
    int q, r, z, lat, dlen;
    string t;
    t = $sformatf("w%0d %0d/%0d", w, a, b);
    run(w, a, b, q, r, z, lat, dlen);
    check({t, " quotient"}, q, exp_q(a, b, w));
    check({t, " remainder"}, r, exp_r(a, b));
    check({t, " div_by_zero"}, z, exp_z(b));
    check({t, " latency"}, lat, exp_lat(b, w));
    check({t, " done_len"}, dlen, 1);
  endtask
  initial begin
    int q, r, z, lat, dlen, e, first, second, ndone;
    b4.start = 0; b4.dividend = 0; b4.divisor = 0;
    b8.start = 0; b8.dividend = 0; b8.divisor = 0;
    tbl = '{'{13, 3, 4, 1}, '{15, 1, 15, 0}, '{5, 7, 0, 5}, '{0, 5, 0, 0},
            '{9, 0, 15, 9}, '{12, 4, 3, 0}, '{7, 2, 3, 1}};
    #12;
    check("reset busy", b4.busy, 0);
    check("reset done", b4.done, 0);
    check("reset quotient", b4.quotient, 0);
    check("reset remainder", b4.remainder, 0);
    check("reset div_by_zero", b4.div_by_zero, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    b4.dividend = 13; b4.divisor = 3; b4.start = 1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      b4.start = 0;
      check($sformatf("13/3 busy e%0d", i), b4.busy, (i <= 5) ? 1 : 0);
      check($sformatf("13/3 done e%0d", i), b4.done, (i == 5) ? 1 : 0);
    end
    check("13/3 quotient hold", b4.quotient, 4);
    check("13/3 remainder hold", b4.remainder, 1);
    for (int i = 0; i < 7; i++) begin
      run(4, tbl[i].a, tbl[i].b, q, r, z, lat, dlen);
      check($sformatf("tbl%0d quotient", i), q, tbl[i].q);
      check($sformatf("tbl%0d remainder", i), r, tbl[i].r);
      check($sformatf("tbl%0d div_by_zero", i), z, exp_z(tbl[i].b));
      check($sformatf("tbl%0d latency", i), lat, exp_lat(tbl[i].b, 4));
      check($sformatf("tbl%0d done_len", i), dlen, 1);
    end
    b4.dividend = 13; b4.divisor = 3; b4.start = 1;
    @(posedge clk); #1;
    b4.start = 0;
    @(posedge clk); #1;
    b4.dividend = 12; b4.divisor = 4; b4.start = 1;
    @(posedge clk); #1;
    b4.start = 0;
    e = 3;
    while (!b4.done && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    check("ignored start latency", e, 5);
    check("ignored start quotient", b4.quotient, 4);
    check("ignored start remainder", b4.remainder, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ignored start not queued", b4.busy, 0);
    do_case(4, 12, 4);
    b4.dividend = 13; b4.divisor = 3; b4.start = 1;
    @(posedge clk); #1;
    b4.start = 0;
    @(posedge clk); #3;
    rst = 1;
    #1;
    check("abort busy", b4.busy, 0);
    check("abort done", b4.done, 0);
    check("abort quotient", b4.quotient, 0);
    check("abort remainder", b4.remainder, 0);
    check("abort div_by_zero", b4.div_by_zero, 0);
    @(negedge clk); rst = 0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b4.done) ndone++;
    end
    check("abort no done", ndone, 0);
    do_case(4, 7, 2);
    b4.dividend = 1; b4.divisor = 1; b4.start = 1;
    first = -1; second = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (b4.done) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    b4.start = 0;
    check("held start period", second - first, 6);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_case(4, a, b);
    do_case(8, 200, 0);
    do_case(8, 255, 1);
    for (int i = 0; i < 150; i++)
      do_case(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
